pwm_cfg_ctrl: RTL
=================

// Module: pwm_cfg_ctrl
// PURPOSE
//  Register-mapped configuration controller for N_CH pwm2 channels. Bus writes land in per-channel
//  shadow registers. A commit copies shadow to the active outputs glitch-free, at the channel's
//  period boundary, so a running waveform never sees a torn config. Sits between the core bus and the PWM channels.
// PARAMETERS
//  N_CH    2   number of PWM channels (1..8)
//  ADDR_W  8   byte address width; channel c occupies 0x20*c .. 0x20*c+0x1F
// PORTS
//  clk_i          in   1          sole clock, rising edge
//  rst_i          in   1          asynchronous, active-low reset
//  req_valid_i    in   1          bus request valid
//  req_ready_o    out  1          request accepted when valid&ready
//  req_we_i       in   1          1=write, 0=read
//  req_addr_i     in   ADDR_W     byte address
//  req_wdata_i    in   32         write data
//  rsp_valid_o    out  1          one-cycle response strobe
//  rsp_rdata_o    out  32         read data (0 on writes/errors)
//  rsp_err_o      out  1          access error, valid with rsp_valid_o
//  pwm_wrap_i     in   N_CH       per-channel pulse: counter == period-1 (period boundary)
//  pwm_mode_o     out  2*N_CH     active mode (0 off, 1 standard, 2 heartbeat)
//  pwm_period_o   out  32*N_CH    active period
//  pwm_thr1_o     out  32*N_CH    active threshold1
//  pwm_thr2_o     out  32*N_CH    active threshold2
//  pwm_step_o     out  12*N_CH    active heartbeat step
//  irq_o          out  1          OR of per-channel applied-sticky & irq-enable
// BEHAVIOUR
//  Register map (offset in channel): 0x00 MODE[1:0], 0x04 PERIOD, 0x08 THR1, 0x0C THR2, 0x10 STEP[11:0],
//   0x14 CTRL (W: b0 commit, b1 force, b2 irq_en RW; b0/b1 self-clear, read 0),
//   0x18 STATUS (RO: b0 pending, b1 applied-sticky; write 1 to b1 clears it), 0x1C reserved.
//  Reset (async, rst_i=0): all shadow+active regs 0, pending=0, sticky=0, irq_en=0,
//   rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=0; req_ready_o=1 from first clock after release.
//  Handshake: req_ready_o held 1; accepted request -> rsp_valid_o exactly 1 cycle later, no backpressure.
//   Reads return shadow values (zero-extended) and STATUS; reads of active values are not provided.
//  Errors (rsp_err_o=1, no state change, rdata 0): addr[1:0]!=0; channel index >= N_CH;
//   offset 0x1C; write to 0x18 with b1=0 is a silent no-op (no error); MODE write of 3 -> error, shadow kept.
//  Per-channel FSM: IDLE --commit--> PENDING --apply--> IDLE.
//   Apply condition in PENDING: pwm_wrap_i[c]=1, OR active mode==0 (channel stopped).
//   Force (b1) applies in the accept cycle's next edge regardless of wrap; force beats commit if both set.
//   Apply: active <= shadow as registered before this edge (same-edge shadow write is NOT included); sticky<=1.
//  Active outputs change only on an apply edge; apply latency = 1 edge after wrap seen in PENDING.
//  Commit while PENDING: stays PENDING (idempotent). Commit on same edge as apply: apply proceeds,
//   state stays PENDING so the just-written commit is honoured at next wrap.
//  Shadow writes during PENDING allowed; latest shadow at apply edge wins.
//  Sticky set and W1C on same edge: set wins. irq_o registered, 1 cycle after sticky rises.
//  Widths: PERIOD/THR writes take wdata[31:0]; STEP takes wdata[11:0]; MODE takes wdata[1:0] (upper bits ignored).
//  Reset mid-PENDING: pending dropped, outputs 0 asynchronously; downstream PWM sees mode 0 (output low).
// STRUCTURE
//  pwm_cfg_pkg: register offsets, CTRL/STATUS bit indices, mode encodings (MODE_OFF/STD/HEART), CH_STRIDE=0x20.
//  Sub-module pwm_cfg_chan: one channel's shadow regs, active regs, IDLE/PENDING FSM, sticky/irq_en;
//   instantiated N_CH times in a generate loop. Top holds address decode, error check, response register.
// TESTING
//  1 Reset: rst_i low mid-run -> all pwm_*_o=0, rsp_valid_o=0 immediately; ready=1 one edge after release.
//  2 Write ch0 PERIOD=100, THR1=40, MODE=1, commit while active mode 0 -> active updates next edge, sticky=1.
//  3 Ch0 running: write THR1=60, commit; no wrap for 50 cycles -> outputs hold 40; wrap pulse -> 60 next edge.
//  4 Errors: addr 0x02, addr 0x40 (N_CH=2), MODE=3 -> rsp_err_o=1, shadow/readback unchanged.
//  5 Commit same edge as ch0 wrap while PENDING -> apply happens, STATUS.pending reads 1 afterwards.
//  6 Force commit with irq_en=1 -> apply next edge, irq_o=1 one cycle later; W1C STATUS b1 -> irq_o=0.

Source files
------------

// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration controller: register map,
// control/status bit positions, mode encodings and the per-channel config record.
package pwm_cfg_pkg;

    localparam int unsigned CH_STRIDE = 32'h20;

    localparam logic [4:0] OFF_MODE   = 5'h00;
    localparam logic [4:0] OFF_PERIOD = 5'h04;
    localparam logic [4:0] OFF_THR1   = 5'h08;
    localparam logic [4:0] OFF_THR2   = 5'h0C;
    localparam logic [4:0] OFF_STEP   = 5'h10;
    localparam logic [4:0] OFF_CTRL   = 5'h14;
    localparam logic [4:0] OFF_STATUS = 5'h18;
    localparam logic [4:0] OFF_RSVD   = 5'h1C;

    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_FORCE   = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned STAT_PENDING = 0;
    localparam int unsigned STAT_APPLIED = 1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_STD   = 2'd1;
    localparam logic [1:0] MODE_HEART = 2'd2;

    typedef enum logic {StIdle, StPending} chan_state_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] period;
        logic [31:0] thr1;
        logic [31:0] thr2;
        logic [11:0] step;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_cfg_ctrl_if.sv
// Request/response bus between the core and the PWM configuration controller.
interface pwm_cfg_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/pwm_cfg_chan.sv
// One PWM channel: shadow and active config, IDLE/PENDING commit FSM, applied-sticky and irq.
module pwm_cfg_chan
    import pwm_cfg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [4:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic        wrap_i,
    output logic [31:0] rdata_o,
    output pwm_cfg_t    active_o,
    output logic        irq_o
);

    pwm_cfg_t    shadow_q, shadow_d, active_q, active_d;
    chan_state_e state_q, state_d;
    logic        sticky_q, sticky_d, irq_en_q, irq_en_d, irq_q;
    logic        commit, force_req, apply;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            active_q <= '0;
            state_q  <= StIdle;
            sticky_q <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            state_q  <= state_d;
            sticky_q <= sticky_d;
            irq_en_q <= irq_en_d;
            irq_q    <= sticky_q & irq_en_q;
        end
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        state_d   = state_q;
        sticky_d  = sticky_q;
        irq_en_d  = irq_en_q;
        apply     = 1'b0;
        commit    = wr_en_i && (off_i == OFF_CTRL) && wdata_i[CTRL_COMMIT];
        force_req = wr_en_i && (off_i == OFF_CTRL) && wdata_i[CTRL_FORCE];

        if (wr_en_i) begin
            unique case (off_i)
                OFF_MODE:   shadow_d.mode   = wdata_i[1:0];
                OFF_PERIOD: shadow_d.period = wdata_i;
                OFF_THR1:   shadow_d.thr1   = wdata_i;
                OFF_THR2:   shadow_d.thr2   = wdata_i;
                OFF_STEP:   shadow_d.step   = wdata_i[11:0];
                OFF_CTRL:   irq_en_d        = wdata_i[CTRL_IRQ_EN];
                OFF_STATUS: if (wdata_i[STAT_APPLIED]) sticky_d = 1'b0;
                default: ;
            endcase
        end

        if (force_req) begin
            apply   = 1'b1;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (commit) state_d = StPending;
                StPending: begin
                    // A stopped channel has no boundary to wait for.
                    if (wrap_i || (active_q.mode == MODE_OFF)) begin
                        apply   = 1'b1;
                        state_d = commit ? StPending : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Registered shadow only: a same-edge shadow write lands after the copy.
        if (apply) begin
            active_d = shadow_q;
            sticky_d = 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (off_i)
            OFF_MODE:   rdata_o = {30'd0, shadow_q.mode};
            OFF_PERIOD: rdata_o = shadow_q.period;
            OFF_THR1:   rdata_o = shadow_q.thr1;
            OFF_THR2:   rdata_o = shadow_q.thr2;
            OFF_STEP:   rdata_o = {20'd0, shadow_q.step};
            OFF_CTRL:   rdata_o = {29'd0, irq_en_q, 2'b00};
            OFF_STATUS: rdata_o = {30'd0, sticky_q, state_q == StPending};
            default: ;
        endcase
    end

    assign active_o = active_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// Register-mapped config controller for N_CH PWM channels: address decode, error
// checking and the one-cycle response register around per-channel shadow/active blocks.
module pwm_cfg_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pwm_cfg_ctrl_if.slave        bus_io,
    input  logic [N_CH-1:0]      pwm_wrap_i,
    output logic [2*N_CH-1:0]    pwm_mode_o,
    output logic [32*N_CH-1:0]   pwm_period_o,
    output logic [32*N_CH-1:0]   pwm_thr1_o,
    output logic [32*N_CH-1:0]   pwm_thr2_o,
    output logic [12*N_CH-1:0]   pwm_step_o,
    output logic                 irq_o
);

    localparam int unsigned CH_W = ADDR_W - 5;

    logic              ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d, rd_mux;
    logic              accept, err;
    logic [CH_W-1:0]   ch_idx;
    logic [4:0]        off;
    logic [N_CH-1:0]   wr_en, chan_irq;
    logic [31:0]       chan_rdata  [N_CH];
    pwm_cfg_t          chan_active [N_CH];

    assign accept = bus_io.req_valid && ready_q;
    assign ch_idx = bus_io.req_addr[ADDR_W-1:5];
    assign off    = bus_io.req_addr[4:0];

    always_comb begin
        err = (bus_io.req_addr[1:0] != 2'b00)
           || (32'(ch_idx) >= N_CH)
           || (off == OFF_RSVD)
           || (bus_io.req_we && (off == OFF_MODE) && (bus_io.req_wdata[1:0] == 2'd3));
    end

    always_comb begin
        wr_en  = '0;
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                wr_en[c] = accept && bus_io.req_we && !err;
                rd_mux   = chan_rdata[c];
            end
        end
        rsp_rdata_d = (accept && !bus_io.req_we && !err) ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ready_q     <= 1'b1;
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus_io.req_ready = ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        pwm_cfg_chan u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_i),
            .wr_en_i  (wr_en[c]),
            .off_i    (off),
            .wdata_i  (bus_io.req_wdata),
            .wrap_i   (pwm_wrap_i[c]),
            .rdata_o  (chan_rdata[c]),
            .active_o (chan_active[c]),
            .irq_o    (chan_irq[c])
        );

        assign pwm_mode_o[2*c +: 2]    = chan_active[c].mode;
        assign pwm_period_o[32*c +: 32] = chan_active[c].period;
        assign pwm_thr1_o[32*c +: 32]   = chan_active[c].thr1;
        assign pwm_thr2_o[32*c +: 32]   = chan_active[c].thr2;
        assign pwm_step_o[12*c +: 12]   = chan_active[c].step;
    end

    assign irq_o = |chan_irq;

endmodule
